adpcm_encoder: RTL and testbench
================================

Name: adpcm_encoder

Overview:
Streaming IMA-ADPCM encoder: converts one signed 16-bit PCM sample into one 4-bit code (sign + 3 magnitude bits). It is the transmit-side counterpart of the decoder's inverse-quantization stage. The encoder keeps its own predictor and step-index state, and reconstructs with exactly the decoder's arithmetic so both predictors track bit-for-bit. It sits between the PCM sample source and the code packer, with a valid/ready handshake on both sides.

Parameters:
RESET_INDEX, 0, step index loaded on rst (range 0..88)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clear  in  1  sync; loads init_pred/init_index, aborts any sample in flight
init_pred  in  16  signed predictor value loaded by clear
init_index  in  7  step index loaded by clear (values >88 saturate to 88)
in_valid  in  1  in_sample valid
in_ready  out  1  encoder can accept a sample
in_sample  in  16  signed PCM sample
out_valid  out  1  out_code valid
out_ready  in  1  downstream accepts code
out_code  out  4  ADPCM code; [3]=sign, [2:0]=magnitude
pred_out  out  16  current predictor, updated after each encode
index_out  out  7  current step index

Behaviour:
- Reset: state=IDLE, predictor=0, index=RESET_INDEX, in_ready=1, out_valid=0, out_code=0.
- FSM states: IDLE, DIFF, Q2, Q1, Q0, UPD, OUT.
- IDLE: in_ready=1. On in_valid, latch in_sample and go to DIFF.
- DIFF: compute diff = sext17(sample) - sext17(predictor).
  - code[3] = (diff<0).
  - mag = |diff| (17-bit unsigned).
  - step = STEP_TABLE[index].
- Q2: if mag >= step, set code[2] and subtract step from mag.
- Q1: same test with step>>1, setting code[1].
- Q0: same test with step>>2, setting code[0].
- UPD: reconstruct exactly as the decoder does.
  - diffq = (step>>3) + (code[2]?step:0) + (code[1]?step>>1:0) + (code[0]?step>>2:0), in 19-bit width.
  - p = predictor ∓ diffq, sign-extended to 19 bits; subtract when code[3]=1.
  - Clamp p to [-32768, 32767].
  - index += IDX_ADJ[code[2:0]], clamped to [0,88].
- OUT: out_valid=1 and out_code stable. On out_ready go to IDLE. While out_ready=0, hold with all outputs stable.
- Timing: latency from input accept to out_valid is 6 cycles. Throughput is at most one sample per 7 cycles.
- in_ready is 1 only in IDLE. pred_out/index_out change only on the UPD->OUT edge.
- clear: has priority over all states; next state is IDLE.
  - predictor <= init_pred; index <= min(init_index,88).
  - out_valid drops next cycle and the in-flight sample is discarded.
  - In the same cycle, clear has priority over in_valid.
- rst has priority over clear.
- Magnitude compare: mag is 17 bits; step extends to 17 bits before compare (max diff 65535).

Decomposition:
- adpcm_pkg holds:
  - STEP_TABLE[0:88]: the standard IMA table, 7..32767.
  - IDX_ADJ[0:7] = {-1,-1,-1,-1,2,4,6,8}.
  - IDX_MAX=88.
  - State enum typedef.
  - Shared clamp16 function, so the decoder uses the identical saturation.
- Sub-module adpcm_step_rom: combinational index->step lookup, shareable with the decoder.

Test Plan:
- Reset, then sample 0 -> code 0x0, pred_out 0, index_out 0 (clamped from -1); out_valid 6 cycles after accept.
- From reset, sample 100 -> code 0x7, pred_out 11, index_out 8. Then sample -100 -> code 0xF and the predictor decreases with step 16.
- From reset, sample -100 -> code 0xF, pred_out 0xFFF5, index_out 8.
- Positive saturation: clear with init_pred=0x7FF0, init_index=88, then sample 0x7FFF -> code 0x0, pred_out 0x7FFF, index_out 87.
  - Then clear to the same init and send sample 0x8000 -> code 0xF, pred_out 0x8FF4, index_out 88 (clamped).
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid/out_code stable, in_ready=0. Release -> one transfer, then in_ready=1.
- Abort: assert clear during Q1 -> next cycle IDLE, out_valid never rises for that sample, predictor equals init_pred. Also assert clear together with in_valid in IDLE -> sample not accepted.

Source files
------------

// File: rtl/adpcm_pkg.sv
// Shared IMA-ADPCM definitions: step table, index adjust table, FSM states and
// the saturation helpers used identically by the encoder and the decoder.
package adpcm_pkg;

  localparam int IDX_MAX = 88;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIFF = 3'd1,
    S_Q2   = 3'd2,
    S_Q1   = 3'd3,
    S_Q0   = 3'd4,
    S_UPD  = 3'd5,
    S_OUT  = 3'd6
  } state_e;

  localparam logic [15:0] STEP_TABLE [0:IDX_MAX] = '{
    16'd7,     16'd8,     16'd9,     16'd10,    16'd11,    16'd12,    16'd13,    16'd14,
    16'd16,    16'd17,    16'd19,    16'd21,    16'd23,    16'd25,    16'd28,    16'd31,
    16'd34,    16'd37,    16'd41,    16'd45,    16'd50,    16'd55,    16'd60,    16'd66,
    16'd73,    16'd80,    16'd88,    16'd97,    16'd107,   16'd118,   16'd130,   16'd143,
    16'd157,   16'd173,   16'd190,   16'd209,   16'd230,   16'd253,   16'd279,   16'd307,
    16'd337,   16'd371,   16'd408,   16'd449,   16'd494,   16'd544,   16'd598,   16'd658,
    16'd724,   16'd796,   16'd876,   16'd963,   16'd1060,  16'd1166,  16'd1282,  16'd1411,
    16'd1552,  16'd1707,  16'd1878,  16'd2066,  16'd2272,  16'd2499,  16'd2749,  16'd3024,
    16'd3327,  16'd3660,  16'd4026,  16'd4428,  16'd4871,  16'd5358,  16'd5894,  16'd6484,
    16'd7132,  16'd7845,  16'd8630,  16'd9493,  16'd10442, 16'd11487, 16'd12635, 16'd13899,
    16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794,
    16'd32767
  };

  localparam logic signed [7:0] IDX_ADJ [0:7] = '{
    -8'sd1, -8'sd1, -8'sd1, -8'sd1, 8'sd2, 8'sd4, 8'sd6, 8'sd8
  };

  // Saturate a widened predictor sum back into the signed 16-bit PCM range.
  function automatic logic [15:0] clamp16(input logic signed [18:0] v);
    if (v > 19'sd32767) begin
      return 16'h7FFF;
    end else if (v < -19'sd32768) begin
      return 16'h8000;
    end else begin
      return v[15:0];
    end
  endfunction

  function automatic logic [6:0] clamp_index(input logic signed [8:0] v);
    if (v < 9'sd0) begin
      return 7'd0;
    end else if (v > 9'(IDX_MAX)) begin
      return 7'(IDX_MAX);
    end else begin
      return v[6:0];
    end
  endfunction

endpackage

// File: rtl/adpcm_step_rom.sv
// Combinational step-index to quantizer step lookup; out-of-range indices
// read the last table entry.
module adpcm_step_rom
  import adpcm_pkg::*;
(
  input  logic [6:0]  index_i,
  output logic [15:0] step_o
);

  always_comb begin
    step_o = STEP_TABLE[IDX_MAX];
    if (index_i <= 7'(IDX_MAX)) begin
      step_o = STEP_TABLE[index_i];
    end
  end

endmodule

// File: rtl/adpcm_encoder.sv
// Multi-cycle IMA-ADPCM encoder: one 16-bit PCM sample in, one 4-bit code out,
// with a decoder-identical reconstruction keeping the predictor in lock-step.
module adpcm_encoder
  import adpcm_pkg::*;
#(
  parameter int RESET_INDEX = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [15:0] init_pred,
  input  logic [6:0]  init_index,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_sample,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_code,
  output logic [15:0] pred_out,
  output logic [6:0]  index_out,
  output state_e      dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both 1. in_ready is high only in IDLE; out_valid is high only in OUT
  // and out_code is held stable there until out_ready is seen.

  state_e      state_q;
  logic [15:0] sample_q;
  logic [15:0] pred_q;
  logic [6:0]  index_q;
  logic [16:0] mag_q;
  logic [16:0] step_q;
  logic [3:0]  code_q;
  logic [3:0]  out_code_q;
  logic        in_ready_q;
  logic        out_valid_q;

  logic [15:0]        rom_step;
  logic signed [16:0] diff;
  logic [16:0]        mag;
  logic [16:0]        q_step;
  logic [1:0]         q_bit;
  logic               q_hit;
  logic [18:0]        diffq;
  logic signed [18:0] pred_ext;
  logic signed [18:0] p_sum;
  logic signed [8:0]  idx_adj;
  logic signed [8:0]  idx_sum;
  logic [15:0]        pred_d;
  logic [6:0]         index_d;

  adpcm_step_rom u_step_rom (
    .index_i (index_q),
    .step_o  (rom_step)
  );

  always_comb begin
    diff = $signed({sample_q[15], sample_q}) - $signed({pred_q[15], pred_q});
    mag  = diff[16] ? (~$unsigned(diff) + 17'd1) : $unsigned(diff);
  end

  // Successive approximation: each Q state tests the residual magnitude
  // against a progressively halved step.
  always_comb begin
    q_step = step_q;
    q_bit  = 2'd2;
    case (state_q)
      S_Q1: begin
        q_step = step_q >> 1;
        q_bit  = 2'd1;
      end
      S_Q0: begin
        q_step = step_q >> 2;
        q_bit  = 2'd0;
      end
      default: begin
        q_step = step_q;
        q_bit  = 2'd2;
      end
    endcase
    q_hit = (mag_q >= q_step);
  end

  always_comb begin
    diffq = 19'(step_q >> 3)
          + (code_q[2] ? 19'(step_q)      : 19'd0)
          + (code_q[1] ? 19'(step_q >> 1) : 19'd0)
          + (code_q[0] ? 19'(step_q >> 2) : 19'd0);
    pred_ext = $signed({{3{pred_q[15]}}, pred_q});
    p_sum    = code_q[3] ? (pred_ext - $signed(diffq)) : (pred_ext + $signed(diffq));
    pred_d   = clamp16(p_sum);
    idx_adj  = 9'(IDX_ADJ[code_q[2:0]]);
    idx_sum  = $signed({2'b00, index_q}) + idx_adj;
    index_d  = clamp_index(idx_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sample_q    <= 16'd0;
      pred_q      <= 16'd0;
      index_q     <= 7'(RESET_INDEX);
      mag_q       <= 17'd0;
      step_q      <= 17'd0;
      code_q      <= 4'd0;
      out_code_q  <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      state_q     <= S_IDLE;
      pred_q      <= init_pred;
      index_q     <= clamp_index($signed({2'b00, init_index}));
      code_q      <= 4'd0;
      out_code_q  <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sample_q   <= in_sample;
            in_ready_q <= 1'b0;
            state_q    <= S_DIFF;
          end
        end
        S_DIFF: begin
          code_q  <= {diff[16], 3'b000};
          mag_q   <= mag;
          step_q  <= {1'b0, rom_step};
          state_q <= S_Q2;
        end
        S_Q2, S_Q1, S_Q0: begin
          if (q_hit) begin
            code_q[q_bit] <= 1'b1;
            mag_q         <= mag_q - q_step;
          end
          state_q <= (state_q == S_Q2) ? S_Q1 :
                     (state_q == S_Q1) ? S_Q0 : S_UPD;
        end
        S_UPD: begin
          pred_q      <= pred_d;
          index_q     <= index_d;
          out_code_q  <= code_q;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign pred_out  = pred_q;
  assign index_out = index_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adpcm_encoder.sv
// Directed bench for adpcm_encoder: hand-computed codes, predictor and index
// values for normal, saturating, backpressure and abort scenarios.
module tb_adpcm_encoder;
  import adpcm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] init_pred = 16'd0;
  logic [6:0]  init_index = 7'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_sample = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_code;
  logic [15:0] pred_out;
  logic [6:0]  index_out;
  state_e      dbg_state;

  int checks = 0;
  int failures = 0;

  adpcm_encoder #(.RESET_INDEX(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .init_pred  (init_pred),
    .init_index (init_index),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .pred_out   (pred_out),
    .index_out  (index_out),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_clear(input logic [15:0] p, input logic [6:0] idx);
    init_pred  = p;
    init_index = idx;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // One sample through the encoder; hold keeps out_ready low for that many
  // cycles after out_valid rises.
  task automatic send(input string tag, input logic [15:0] s, input logic [3:0] ec,
                      input logic [15:0] ep, input logic [6:0] ei, input int hold);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
    in_sample = s;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd6);
    check({tag, "_code"}, 32'(out_code), 32'(ec));
    check({tag, "_pred"}, 32'(pred_out), 32'(ep));
    check({tag, "_index"}, 32'(index_out), 32'(ei));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_code"}, 32'(out_code), 32'(ec));
      check({tag, "_hold_pred"}, 32'(pred_out), 32'(ep));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_post"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic seen_valid;

    // Reset state
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_code", 32'(out_code), 32'd0);
    check("rst_pred", 32'(pred_out), 32'd0);
    check("rst_index", 32'(index_out), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // Zero sample: index clamps from -1 to 0
    send("zero", 16'd0, 4'h0, 16'h0000, 7'd0, 0);

    // +100 then -100: step 7 then step 16
    do_reset();
    send("p100", 16'd100, 4'h7, 16'd11, 7'd8, 0);
    send("m100_after", 16'hFF9C, 4'hF, 16'hFFED, 7'd16, 0);

    // -100 from reset
    do_reset();
    send("m100", 16'hFF9C, 4'hF, 16'hFFF5, 7'd8, 0);

    // init_index above 88 saturates on clear
    do_clear(16'h1234, 7'd120);
    check("clear_sat_index", 32'(index_out), 32'd88);
    check("clear_pred", 32'(pred_out), 32'h1234);

    // Positive and negative predictor saturation at the top step
    do_clear(16'h7FF0, 7'd88);
    send("sat_pos", 16'h7FFF, 4'h0, 16'h7FFF, 7'd87, 0);
    do_clear(16'h7FF0, 7'd88);
    send("sat_neg", 16'h8000, 4'hF, 16'h8FF4, 7'd88, 0);

    // Backpressure: out_ready held low for 10 cycles
    do_reset();
    send("bp", 16'd100, 4'h7, 16'd11, 7'd8, 10);

    // Abort during Q1
    do_reset();
    in_sample = 16'd100;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (dbg_state != S_Q1 && n < 20) begin
      tick();
      n++;
    end
    check("abort_reach_q1", 32'(dbg_state), 32'(S_Q1));
    do_clear(16'h0ABC, 7'd5);
    check("abort_state", 32'(dbg_state), 32'(S_IDLE));
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_pred", 32'(pred_out), 32'h0ABC);
    check("abort_index", 32'(index_out), 32'd5);
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    check("abort_no_valid", 32'(seen_valid), 32'd0);
    check("abort_pred_kept", 32'(pred_out), 32'h0ABC);

    // clear wins over in_valid in IDLE
    in_sample  = 16'd500;
    in_valid   = 1'b1;
    init_pred  = 16'h0ABC;
    init_index = 7'd5;
    clear      = 1'b1;
    tick();
    in_valid = 1'b0;
    clear    = 1'b0;
    check("clr_iv_state", 32'(dbg_state), 32'(S_IDLE));
    check("clr_iv_in_ready", 32'(in_ready), 32'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    check("clr_iv_no_valid", 32'(seen_valid), 32'd0);

    // Encoding continues normally after the aborts: pred 0x0ABC, step 12
    send("post_abort", 16'h0ABC, 4'h0, 16'h0ABD, 7'd4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
